interval_timer: RTL and testbench

- Downstream consumer of the time-parameter store. Samples the 4-bit interval length `Value` when the traffic-light FSM pulses `Start_Timer`, then counts it down in whole seconds.
- Seconds come from an internal divider of `clock`.
- Reports completion to the FSM with a one-cycle `Expired` pulse.
- Also exports the 1 Hz enable and the remaining count for the walk/display logic.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/interval_timer_if.sv | 27 ++
 rtl/one_hz_divider.sv | 31 +++
 rtl/interval_timer.sv | 69 ++++++
 tb/tb_interval_timer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: widths, timer state
// encoding and the interval-select codes used by the FSM and parameter store.
package traffic_pkg;

  localparam int VAL_W             = 4;
  localparam int DIV_COUNT_DEFAULT = 50_000_000;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } timer_state_t;

  typedef enum logic [1:0] {
    SEL_GREEN  = 2'd0,
    SEL_YELLOW = 2'd1,
    SEL_WALK   = 2'd2,
    SEL_RED    = 2'd3
  } interval_sel_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interval_timer_if.sv
// Request/status bundle between the traffic-light FSM (master) and the
// interval timer (slave).
interface interval_timer_if;
  import traffic_pkg::*;

  // Start_Timer is a single-cycle command with no ready: the timer accepts it
  // in every state, sampling Value only in that cycle. Expired and
  // One_Hz_Enable are one-cycle pulses with no back-pressure.
  logic [VAL_W-1:0] Value;
  logic             Start_Timer;
  logic             Expired;
  logic             Busy;
  logic [VAL_W-1:0] Remaining;
  logic             One_Hz_Enable;
  timer_state_t     State;

  modport master (
    output Value, Start_Timer,
    input  Expired, Busy, Remaining, One_Hz_Enable, State
  );

  modport slave (
    input  Value, Start_Timer,
    output Expired, Busy, Remaining, One_Hz_Enable, State
  );

endinterface

// File: rtl/one_hz_divider.sv
// Free-running divider producing a one-cycle tick every DIV_COUNT clocks;
// restart realigns the phase so the next tick is a full period away.
module one_hz_divider
  import traffic_pkg::*;
#(
  parameter int DIV_COUNT = DIV_COUNT_DEFAULT
) (
  input  logic clock,
  input  logic Reset_Sync,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV_COUNT);
  localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      r_div_cnt <= '0;
    end else if (restart || (r_div_cnt == LAST)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign tick = (r_div_cnt == LAST);

endmodule

// File: rtl/interval_timer.sv
// Interval timer: loads a seconds count on Start_Timer, counts it down on the
// 1 Hz tick and pulses Expired for one cycle when it runs out.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int DIV_COUNT = DIV_COUNT_DEFAULT
) (
  input  logic             clock,
  input  logic             Reset_Sync,
  interval_timer_if.slave  tif
);

  logic             w_tick;
  timer_state_t     r_state,     w_state_nxt;
  logic [VAL_W-1:0] r_remaining, w_remaining_nxt;
  logic             r_expired,   w_expired_nxt;

  one_hz_divider #(.DIV_COUNT(DIV_COUNT)) u_divider (
    .clock      (clock),
    .Reset_Sync (Reset_Sync),
    .restart    (tif.Start_Timer),
    .tick       (w_tick)
  );

  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_expired   <= w_expired_nxt;
    end
  end

  // Start has priority over a coincident final tick, which cancels that expiry.
  // A zero-length request completes immediately without entering COUNT.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_expired_nxt   = 1'b0;
    if (tif.Start_Timer) begin
      if (tif.Value == '0) begin
        w_state_nxt     = IDLE;
        w_remaining_nxt = '0;
        w_expired_nxt   = 1'b1;
      end else begin
        w_state_nxt     = COUNT;
        w_remaining_nxt = tif.Value;
      end
    end else if ((r_state == COUNT) && w_tick) begin
      if (r_remaining > VAL_W'(1)) begin
        w_remaining_nxt = r_remaining - VAL_W'(1);
      end else begin
        w_state_nxt     = IDLE;
        w_remaining_nxt = '0;
        w_expired_nxt   = 1'b1;
      end
    end
  end

  assign tif.Expired       = r_expired;
  assign tif.Busy          = (r_state == COUNT);
  assign tif.Remaining     = r_remaining;
  assign tif.One_Hz_Enable = w_tick;
  assign tif.State         = r_state;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: directed scenarios plus random starts, checked
// against an interval/deadline model of the timer.
module tb_interval_timer;
  import traffic_pkg::*;

  localparam int DIV = 4;

  logic clock = 1'b0;
  logic Reset_Sync;

  interval_timer_if tif ();

  interval_timer #(.DIV_COUNT(DIV)) dut (
    .clock      (clock),
    .Reset_Sync (Reset_Sync),
    .tif        (tif)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Model: the active interval (start edge, length), the divider phase origin
  // and the queue of edges after which Expired must be high.
  bit               m_active = 1'b0;
  int               m_s = 0;
  int               m_v = 0;
  int               m_p = 0;
  logic [31:0]      exp_q[$];
  logic [VAL_W-1:0] e_rem;
  logic             e_busy, e_exp, e_tick;

  task automatic model_clear();
    m_active = 1'b0;
    exp_q.delete();
    m_p = edge_n;
  endtask

  task automatic eval_model();
    int e;
    e      = edge_n;
    e_tick = (((e - m_p) % DIV) == DIV - 1);
    if (m_active && (e < m_s + m_v * DIV)) begin
      e_rem  = VAL_W'(m_v - (e - m_s) / DIV);
      e_busy = 1'b1;
    end else begin
      e_rem  = '0;
      e_busy = 1'b0;
    end
    e_exp = (exp_q.size() > 0) && (exp_q[0] == 32'(e));
    while ((exp_q.size() > 0) && (exp_q[0] <= 32'(e))) void'(exp_q.pop_front());
  endtask

  // Advance one edge, apply what the DUT sampled there to the model, then
  // settle to 1 time unit after the edge for observation.
  task automatic step();
    @(posedge clock);
    edge_n++;
    if (Reset_Sync) begin
      model_clear();
    end else if (tif.Start_Timer) begin
      m_active = 1'b1;
      m_s      = edge_n;
      m_v      = int'(tif.Value);
      m_p      = edge_n;
      exp_q.delete();
      exp_q.push_back(32'(edge_n + m_v * DIV));
    end
    eval_model();
    #1;
  endtask

  task automatic test_reset();
    Reset_Sync      = 1'b1;
    tif.Start_Timer = 1'b0;
    tif.Value       = '0;
    repeat (3) step();
    n_checks++; if (tif.Remaining !== '0) begin n_fail++; $display("FAIL reset_remaining got=%0d exp=0", tif.Remaining); end
    n_checks++; if (tif.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", tif.Busy); end
    n_checks++; if (tif.Expired !== 1'b0) begin n_fail++; $display("FAIL reset_expired got=%b exp=0", tif.Expired); end
    n_checks++; if (tif.One_Hz_Enable !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tif.One_Hz_Enable); end
    Reset_Sync = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (tif.One_Hz_Enable !== e_tick) begin n_fail++; $display("FAIL reset_release_tick edge=%0d got=%b exp=%b", edge_n, tif.One_Hz_Enable, e_tick); end
    end
  endtask

  task automatic test_basic_count();
    tif.Value = 4'd3; tif.Start_Timer = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      tif.Start_Timer = 1'b0;
      tif.Value = VAL_W'($urandom_range(0, 15));
      n_checks++; if (tif.Remaining !== e_rem) begin n_fail++; $display("FAIL basic_remaining edge=%0d got=%0d exp=%0d", edge_n, tif.Remaining, e_rem); end
      n_checks++; if (tif.Busy !== e_busy) begin n_fail++; $display("FAIL basic_busy edge=%0d got=%b exp=%b", edge_n, tif.Busy, e_busy); end
      n_checks++; if (tif.Expired !== e_exp) begin n_fail++; $display("FAIL basic_expired edge=%0d got=%b exp=%b", edge_n, tif.Expired, e_exp); end
      n_checks++; if (tif.One_Hz_Enable !== e_tick) begin n_fail++; $display("FAIL basic_tick edge=%0d got=%b exp=%b", edge_n, tif.One_Hz_Enable, e_tick); end
      if (k == 4) begin n_checks++; if (tif.Remaining !== 4'd2) begin n_fail++; $display("FAIL basic_rem_at_4 got=%0d exp=2", tif.Remaining); end end
      if (k == 12) begin n_checks++; if (tif.Expired !== 1'b1) begin n_fail++; $display("FAIL basic_expired_at_12 got=%b exp=1", tif.Expired); end end
      if (k == 13) begin n_checks++; if (tif.Expired !== 1'b0) begin n_fail++; $display("FAIL basic_expired_at_13 got=%b exp=0", tif.Expired); end end
    end
  endtask

  task automatic test_zero_value();
    tif.Value = 4'd0; tif.Start_Timer = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      tif.Start_Timer = 1'b0;
      n_checks++; if (tif.Remaining !== e_rem) begin n_fail++; $display("FAIL zero_remaining edge=%0d got=%0d exp=%0d", edge_n, tif.Remaining, e_rem); end
      n_checks++; if (tif.Busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy edge=%0d got=%b exp=0", edge_n, tif.Busy); end
      n_checks++; if (tif.Expired !== e_exp) begin n_fail++; $display("FAIL zero_expired edge=%0d got=%b exp=%b", edge_n, tif.Expired, e_exp); end
      n_checks++; if (tif.One_Hz_Enable !== e_tick) begin n_fail++; $display("FAIL zero_tick edge=%0d got=%b exp=%b", edge_n, tif.One_Hz_Enable, e_tick); end
      if (k == 0) begin n_checks++; if (tif.Expired !== 1'b1) begin n_fail++; $display("FAIL zero_expired_now got=%b exp=1", tif.Expired); end end
    end
  endtask

  task automatic test_retrigger();
    tif.Value = 4'd5; tif.Start_Timer = 1'b1;
    for (int k = 0; k < 23; k++) begin
      step();
      tif.Start_Timer = 1'b0;
      n_checks++; if (tif.Remaining !== e_rem) begin n_fail++; $display("FAIL retrig_remaining edge=%0d got=%0d exp=%0d", edge_n, tif.Remaining, e_rem); end
      n_checks++; if (tif.Busy !== e_busy) begin n_fail++; $display("FAIL retrig_busy edge=%0d got=%b exp=%b", edge_n, tif.Busy, e_busy); end
      n_checks++; if (tif.Expired !== e_exp) begin n_fail++; $display("FAIL retrig_expired edge=%0d got=%b exp=%b", edge_n, tif.Expired, e_exp); end
      n_checks++; if (tif.One_Hz_Enable !== e_tick) begin n_fail++; $display("FAIL retrig_tick edge=%0d got=%b exp=%b", edge_n, tif.One_Hz_Enable, e_tick); end
      if (k == 6) begin n_checks++; if (tif.Remaining !== 4'd2) begin n_fail++; $display("FAIL retrig_reload got=%0d exp=2", tif.Remaining); end end
      if (k == 14) begin n_checks++; if (tif.Expired !== 1'b1) begin n_fail++; $display("FAIL retrig_expired_at_14 got=%b exp=1", tif.Expired); end end
      if (k == 20) begin n_checks++; if (tif.Expired !== 1'b0) begin n_fail++; $display("FAIL retrig_stale_expiry got=%b exp=0", tif.Expired); end end
      if (k == 5) begin tif.Value = 4'd2; tif.Start_Timer = 1'b1; end
    end
  endtask

  task automatic test_coincident();
    tif.Value = 4'd2; tif.Start_Timer = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      tif.Start_Timer = 1'b0;
      n_checks++; if (tif.Remaining !== e_rem) begin n_fail++; $display("FAIL coinc_remaining edge=%0d got=%0d exp=%0d", edge_n, tif.Remaining, e_rem); end
      n_checks++; if (tif.Busy !== e_busy) begin n_fail++; $display("FAIL coinc_busy edge=%0d got=%b exp=%b", edge_n, tif.Busy, e_busy); end
      n_checks++; if (tif.Expired !== e_exp) begin n_fail++; $display("FAIL coinc_expired edge=%0d got=%b exp=%b", edge_n, tif.Expired, e_exp); end
      if (k == 8) begin n_checks++; if (tif.Expired !== 1'b0) begin n_fail++; $display("FAIL coinc_start_wins got=%b exp=0", tif.Expired); end end
      if (k == 12) begin n_checks++; if (tif.Expired !== 1'b1) begin n_fail++; $display("FAIL coinc_expired_at_12 got=%b exp=1", tif.Expired); end end
      if (k == 7) begin tif.Value = 4'd1; tif.Start_Timer = 1'b1; end
    end
  endtask

  task automatic test_async_reset();
    tif.Value = 4'd4; tif.Start_Timer = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      tif.Start_Timer = 1'b0;
    end
    #2;
    Reset_Sync = 1'b1;
    #1;
    model_clear();
    eval_model();
    n_checks++; if (tif.Remaining !== '0) begin n_fail++; $display("FAIL async_remaining got=%0d exp=0", tif.Remaining); end
    n_checks++; if (tif.Busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got=%b exp=0", tif.Busy); end
    n_checks++; if (tif.Expired !== 1'b0) begin n_fail++; $display("FAIL async_expired got=%b exp=0", tif.Expired); end
    repeat (2) step();
    Reset_Sync = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      n_checks++; if (tif.Expired !== 1'b0) begin n_fail++; $display("FAIL async_no_expiry edge=%0d got=%b exp=0", edge_n, tif.Expired); end
      n_checks++; if (tif.Busy !== 1'b0) begin n_fail++; $display("FAIL async_busy_after edge=%0d got=%b exp=0", edge_n, tif.Busy); end
      n_checks++; if (tif.One_Hz_Enable !== e_tick) begin n_fail++; $display("FAIL async_tick edge=%0d got=%b exp=%b", edge_n, tif.One_Hz_Enable, e_tick); end
    end
  endtask

  task automatic test_idle_divider();
    int ticks;
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      tif.Value = VAL_W'($urandom_range(0, 15));
      if (tif.One_Hz_Enable === 1'b1) ticks++;
      n_checks++; if (tif.One_Hz_Enable !== e_tick) begin n_fail++; $display("FAIL idle_tick edge=%0d got=%b exp=%b", edge_n, tif.One_Hz_Enable, e_tick); end
      n_checks++; if (tif.Expired !== 1'b0) begin n_fail++; $display("FAIL idle_expired edge=%0d got=%b exp=0", edge_n, tif.Expired); end
    end
    n_checks++; if (ticks != 40 / DIV) begin n_fail++; $display("FAIL idle_tick_count got=%0d exp=%0d", ticks, 40 / DIV); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      step();
      tif.Value       = VAL_W'($urandom_range(0, 7));
      tif.Start_Timer = ($urandom_range(0, 24) == 0);
      n_checks++; if (tif.Remaining !== e_rem) begin n_fail++; $display("FAIL rand_remaining edge=%0d got=%0d exp=%0d", edge_n, tif.Remaining, e_rem); end
      n_checks++; if (tif.Busy !== e_busy) begin n_fail++; $display("FAIL rand_busy edge=%0d got=%b exp=%b", edge_n, tif.Busy, e_busy); end
      n_checks++; if (tif.Expired !== e_exp) begin n_fail++; $display("FAIL rand_expired edge=%0d got=%b exp=%b", edge_n, tif.Expired, e_exp); end
      n_checks++; if (tif.One_Hz_Enable !== e_tick) begin n_fail++; $display("FAIL rand_tick edge=%0d got=%b exp=%b", edge_n, tif.One_Hz_Enable, e_tick); end
    end
    tif.Start_Timer = 1'b0;
  endtask

  initial begin
    Reset_Sync      = 1'b1;
    tif.Start_Timer = 1'b0;
    tif.Value       = '0;
    test_reset();
    test_basic_count();
    test_zero_value();
    test_retrigger();
    test_coincident();
    test_async_reset();
    test_idle_divider();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
